// File: rtl/project_select_ctrl.sv
// project_select_ctrl: Wishbone-programmable owner of the per-project "active"
// enables. Only one project may drive the shared user-area buses at a time.
// Every hand-over is break-before-make: all enables drop, a guard interval
// elapses, and only then does the newly selected enable rise.
module project_select_ctrl #(
  parameter int          NUM_PROJECTS = 3,
  parameter int          GUARD_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic                    la_override,
  input  logic [7:0]              la_sel_id,
  output logic [NUM_PROJECTS-1:0] active,
  output logic                    busy
);

  localparam logic [7:0] ID_NONE    = 8'hFF;
  localparam logic [7:0] NUM_IDS    = 8'(NUM_PROJECTS);
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_ON    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  guard_cnt;
  logic [7:0]  cur_id;
  logic [15:0] switch_cnt;

  logic [7:0]  ctrl_id;
  logic        ctrl_en;
  logic        err;
  logic        bad_q;

  logic [7:0]  req_id;
  logic        req_en;
  logic        req_bad;
  logic [7:0]  target;
  logic [7:0]  status_id;

  logic        wb_hit;
  logic        wb_fire;
  logic [3:0]  wb_offs;
  logic        ctrl_wr;
  logic        err_clr;
  logic [31:0] rdata;

  // Register bits with no function; kept out of the unused-signal report.
  logic        unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[30:10], wbs_dat_i[8]};

  // One-hot decode of a project id; ids outside the project range give zero.
  function automatic logic [NUM_PROJECTS-1:0] onehot(input logic [7:0] id);
    logic [NUM_PROJECTS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PROJECTS; i++) begin
      if (id == 8'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Effective request: the LA override path bypasses the CTRL register entirely.
  always_comb begin
    req_id  = la_override ? la_sel_id : ctrl_id;
    req_en  = la_override | ctrl_en;
    target  = (req_en && (req_id < NUM_IDS)) ? req_id : ID_NONE;
    req_bad = req_en && (req_id != ID_NONE) && (req_id >= NUM_IDS);
  end

  // Bus decode: a transfer fires only when ack is low, so a held strobe
  // is acknowledged on every other cycle.
  always_comb begin
    wb_offs = wbs_adr_i[3:0];
    wb_hit  = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    wb_fire = wb_hit && !wbs_ack_o;
    ctrl_wr = wb_fire && wbs_we_i && (wb_offs == 4'h0) && wbs_sel_i[0];
    err_clr = wb_fire && wbs_we_i && (wb_offs == 4'h4) && wbs_sel_i[1] && wbs_dat_i[9];
  end

  // Read mux; the reported id is meaningful only while a project is on.
  always_comb begin
    status_id = (state == S_ON) ? cur_id : ID_NONE;
    unique case (wb_offs)
      4'h0:    rdata = {ctrl_en, 23'd0, ctrl_id};
      4'h4:    rdata = {21'd0, la_override, err, busy, status_id};
      4'h8:    rdata = {16'd0, switch_cnt};
      default: rdata = 32'd0;
    endcase
  end

  // Wishbone slave: ack, registered read data and the CTRL register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      ctrl_id   <= ID_NONE;
      ctrl_en   <= 1'b0;
    end else begin
      wbs_ack_o <= wb_fire;
      wbs_dat_o <= (wb_fire && !wbs_we_i) ? rdata : 32'd0;
      if (ctrl_wr) begin
        ctrl_en <= wbs_dat_i[31];
        ctrl_id <= wbs_dat_i[7:0];
      end
    end
  end

  // Sticky error: raised when the request first becomes an out-of-range id,
  // so a firmware clear holds while the bad request stays parked.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      err   <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      bad_q <= req_bad;
      if (req_bad && !bad_q) err <= 1'b1;
      else if (err_clr)      err <= 1'b0;
    end
  end

  // Hand-over sequencer with registered enables and busy flag.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state      <= S_IDLE;
      guard_cnt  <= 8'd0;
      cur_id     <= ID_NONE;
      active     <= '0;
      busy       <= 1'b0;
      switch_cnt <= 16'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          active <= '0;
          if (target != ID_NONE) begin
            state     <= S_ARM;
            guard_cnt <= GUARD_LOAD;
            cur_id    <= target;
            busy      <= 1'b1;
          end
        end
        S_ARM: begin
          if (target == ID_NONE) begin
            state  <= S_IDLE;
            cur_id <= ID_NONE;
            busy   <= 1'b0;
          end else if (target != cur_id) begin
            guard_cnt <= GUARD_LOAD;
            cur_id    <= target;
          end else if (guard_cnt == 8'd0) begin
            state      <= S_ON;
            busy       <= 1'b0;
            active     <= onehot(cur_id);
            switch_cnt <= switch_cnt + 16'd1;
          end else begin
            guard_cnt <= guard_cnt - 8'd1;
          end
        end
        S_ON: begin
          if (target != cur_id) begin
            state     <= S_DRAIN;
            guard_cnt <= GUARD_LOAD;
            active    <= '0;
            busy      <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (guard_cnt != 8'd0) begin
            guard_cnt <= guard_cnt - 8'd1;
          end else if (target != ID_NONE) begin
            state     <= S_ARM;
            guard_cnt <= GUARD_LOAD;
            cur_id    <= target;
          end else begin
            state  <= S_IDLE;
            cur_id <= ID_NONE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          active <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/project_select_ctrl.md
Name: project_select_ctrl

Overview:
Wishbone-configurable scheduler that owns the per-project "active" enables of the multi-project user area. Only one wrapped project drives the shared io_out/io_oeb/la1 buses at a time. A hand-over runs as break-before-make: all enables drop, a guard interval elapses, then the new enable rises. Firmware selects projects over Wishbone; a logic-analyzer override path allows selection without the CPU.

Parameters:
NUM_PROJECTS, 3, number of project enables (1..8)
GUARD_CYCLES, 4, idle cycles with all enables low between projects (1..255)
BASE_ADDR, 32'h3000_0000, Wishbone base; registers at +0x0, +0x4, +0x8

Ports:
wb_clk_i  input  1  system clock, all logic on rising edge
wb_rst_ni  input  1  synchronous active-low reset
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte selects (byte 0 required for CTRL write to take effect)
wbs_adr_i  input  32  address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
la_override  input  1  when high, la_sel_id replaces CTRL as the request source
la_sel_id  input  8  override project id; 8'hFF = none
active  output  NUM_PROJECTS  one-hot-or-zero project enables
busy  output  1  switch sequence in progress

Behaviour:
- Reset (wb_rst_ni low at a clock edge): active=0, busy=0, wbs_ack_o=0, wbs_dat_o=0. CTRL.id=8'hFF, CTRL.en=0, switch count=0, err=0. FSM goes to IDLE.
- Registers:
  - 0x0 CTRL rw: [7:0] id, [31] en.
  - 0x4 STATUS ro: [7:0] current id (FF if none), [8] busy, [9] err (sticky; cleared by a STATUS write of bit9=1), [10] la_override.
  - 0x8 COUNT ro: [15:0] completed switches, wraps FFFF->0000.
- Wishbone:
  - A cycle occurs when stb&cyc are high and the address matches.
  - ack rises 1 cycle later, stays high exactly 1 cycle, and is forced low on the following cycle, so a continuously held stb yields ack on every other cycle.
  - Write takes effect on the ack cycle.
  - Read data is valid with ack, otherwise 0.
  - An unmapped address within BASE_ADDR+0x0..0xF acks with data 0.
  - Outside that range: no ack.
- Effective request: if la_override, id=la_sel_id, en=1; otherwise id=CTRL.id, en=CTRL.en. Target = en && id<NUM_PROJECTS ? id : none.
- An id >= NUM_PROJECTS (other than FF) with en=1 sets err and is treated as none.
- FSM:
  - IDLE: active=0. If target != none -> ARM.
  - ARM: active=0, guard counter loaded with GUARD_CYCLES-1. Counts down; at 0 -> ON. Latches target as current.
  - ON: active=onehot(current). If target != current -> DRAIN (target none also goes to DRAIN).
  - DRAIN: active=0, counter loaded GUARD_CYCLES-1, counts down; at 0 -> ARM if target != none, else IDLE.
  - busy=1 in ARM and DRAIN.
  - COUNT increments on each ARM->ON transition.
- Requests during ARM/DRAIN are not queued separately. The target is re-sampled when ARM completes; the last write wins. If the target becomes none during ARM -> IDLE. If the target changes during ARM, restart ARM with the counter reloaded.
- Latency: from the write ack with the FSM in IDLE, active rises after GUARD_CYCLES+1 cycles. ON->new project: enables low for exactly 2*GUARD_CYCLES cycles.
- Never more than one active bit high; never a cycle where old and new are both high.
- Reset mid-sequence: immediate return to IDLE with active=0 on the next edge.

Test Plan:
- Reset, then read 0x4 -> 0x000000FF; active=0, COUNT=0.
- Write CTRL=0x8000_0001, GUARD_CYCLES=4 -> active=3'b010 exactly 5 cycles after ack; COUNT=1; busy high 4 cycles.
- From project 1, write CTRL=0x8000_0002 -> active=000 for 8 cycles, then 3'b100; monitor confirms no overlap; COUNT=2.
- Write CTRL=0x8000_0005 -> err=1, active drains to 0, FSM IDLE. Write STATUS bit9=1 -> err=0.
- During ARM toward project 0, write id=2 -> ARM restarts and project 2 becomes active; project 0 is never asserted.
- With project 2 active, assert la_override with la_sel_id=0 -> switch to 3'b001. Deassert la_override with CTRL.en=0 -> drain to IDLE. Assert reset mid-DRAIN -> active=0, busy=0 next cycle.
